// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_pkg
//  Description : Shared encodings and helpers for the fetch sequencer.
//                - Sequencer state encoding (FETCH/WAIT/EXEC/FAULT)
//                - Operating mode encoding (RUN/STEP/HALT)
//                - Execute-tick divider derivation and sanity check
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

  // Number of clk cycles per execute tick.
  function automatic int calc_div(input int outer_frq, input int inner_frq);
    return outer_frq / inner_frq;
  endfunction

  // FETCH + WAIT + EXEC need at least three cycles per instruction.
  function automatic bit div_is_valid(input int div);
    return div >= 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Free-running modulo-DIV counter producing a one-cycle tick
//                in the cycle where the count equals DIV-1.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset (count returns to 0)
//                tick  - high for exactly one cycle out of every DIV
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int                 C_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(DIV - 1);
  localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

  logic [C_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_count == C_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + C_ONE;
    end
  end

  assign tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Program-counter and fetch controller. Fetches from a
//                combinational IMEM at pc, waits for an execute tick (run
//                mode) or a step edge (step mode), strobes the datapath for
//                one cycle, then advances / branches the pc within the IMEM
//                window. An out-of-window branch locks the sequencer in FAULT
//                until reset.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                mode           - 00 run, 01 step, 10/11 halt
//                step_req       - step button level, rising edge = one step
//                instruction_in - IMEM read data for address pc
//                branch_valid   - branch request, sampled in EXEC only
//                branch_target  - branch destination
//                pc             - fetch address to IMEM
//                instruction    - registered instruction to datapath
//                exec_tick      - one-cycle execute strobe
//                state          - 00 FETCH, 01 WAIT, 10 EXEC, 11 FAULT
//                fault          - sticky out-of-window branch fault
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int OUTER_CLK_FRQ     = 1000000,
  parameter int INTER_CLK_FRQ     = 10,
  parameter int ADDR_WIDTH        = 8,
  parameter int INSTR_WIDTH       = 8,
  parameter int LOWER_IMEM_LIMIT  = 0,
  parameter int HIGHER_IMEM_LIMIT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   step_req,
  input  logic [INSTR_WIDTH-1:0] instruction_in,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   exec_tick,
  output logic [1:0]             state,
  output logic                   fault
);

  localparam int                    DIV         = calc_div(OUTER_CLK_FRQ, INTER_CLK_FRQ);
  localparam logic [ADDR_WIDTH-1:0] C_LOW_ADDR  = ADDR_WIDTH'(LOWER_IMEM_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] C_HIGH_ADDR = ADDR_WIDTH'(HIGHER_IMEM_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] C_ONE_ADDR  = ADDR_WIDTH'(1);

  generate
    if (!div_is_valid(DIV)) begin : g_bad_div
      $error("fetch_sequencer: OUTER_CLK_FRQ/INTER_CLK_FRQ must be >= 3");
    end
    if ((HIGHER_IMEM_LIMIT < LOWER_IMEM_LIMIT) || (LOWER_IMEM_LIMIT < 0) ||
        (longint'(HIGHER_IMEM_LIMIT) >= (longint'(1) << ADDR_WIDTH))) begin : g_bad_window
      $error("fetch_sequencer: IMEM window does not fit the address width");
    end
  endgenerate

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_instruction;
  logic                   r_exec_tick;
  logic                   r_fault;
  logic                   r_step_q;
  logic                   r_pending;

  logic w_tick;
  logic w_step_rise;
  logic w_step_go;
  logic w_run_go;
  logic w_target_ok;

  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_step_rise = step_req & ~r_step_q;
  // A step edge arriving while already in WAIT launches immediately instead
  // of waiting a cycle for the pending flag.
  assign w_step_go   = (mode == MODE_STEP) && (r_pending || w_step_rise);
  assign w_run_go    = (mode == MODE_RUN) && w_tick;
  // Compared as int so a zero lower limit is not a constant-true compare.
  assign w_target_ok = (int'(branch_target) >= LOWER_IMEM_LIMIT) &&
                       (int'(branch_target) <= HIGHER_IMEM_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_FETCH;
      r_pc          <= C_LOW_ADDR;
      r_instruction <= '0;
      r_exec_tick   <= 1'b0;
      r_fault       <= 1'b0;
      r_step_q      <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      r_step_q    <= step_req;
      r_exec_tick <= 1'b0;

      if (mode != MODE_STEP) begin
        r_pending <= 1'b0;
      end else if ((r_state == ST_WAIT) && w_step_go) begin
        r_pending <= 1'b0;
      end else if (w_step_rise) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_FETCH: begin
          r_instruction <= instruction_in;
          r_state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // Ticks seen in other states are simply lost.
          if (w_run_go || w_step_go) begin
            r_state     <= ST_EXEC;
            r_exec_tick <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (branch_valid) begin
            if (w_target_ok) begin
              r_pc    <= branch_target;
              r_state <= ST_FETCH;
            end else begin
              r_fault <= 1'b1;
              r_state <= ST_FAULT;
            end
          end else if (r_pc == C_HIGH_ADDR) begin
            r_pc    <= C_LOW_ADDR;
            r_state <= ST_FETCH;
          end else begin
            r_pc    <= r_pc + C_ONE_ADDR;
            r_state <= ST_FETCH;
          end
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign instruction = r_instruction;
  assign exec_tick   = r_exec_tick;
  assign state       = r_state;
  assign fault       = r_fault;

endmodule
`default_nettype wire
